// File: rtl/motor_pwm_sequencer_pkg.sv
// Shared definitions for the washer motor PWM sequencer: state codes,
// programme mode codes and the microsecond-per-millisecond ratio.
package motor_pwm_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_RUN       = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_DEAD      = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  localparam logic [1:0] MODE_WASH = 2'd0;
  localparam logic [1:0] MODE_SPIN = 2'd1;

  localparam int unsigned US_PER_MS = 1000;

  function automatic logic mode_valid(input logic [1:0] mode);
    return (mode == MODE_WASH) || (mode == MODE_SPIN);
  endfunction

endpackage

// File: rtl/motor_pwm_sequencer_tick_gen.sv
// Turns the asynchronous 1 MHz prescaler level into a one-cycle us_tick and
// derives ms_tick every TICKS_PER_MS us_ticks; the ms divider is clearable.
module motor_pwm_sequencer_tick_gen
  import motor_pwm_sequencer_pkg::*;
#(
  parameter int unsigned TICKS_PER_MS = US_PER_MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_1mhz_clk,
  input  logic i_clr,
  output logic o_us_tick,
  output logic o_ms_tick
);

  localparam int unsigned DIV_W = $clog2(TICKS_PER_MS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICKS_PER_MS - 1);

  // [0],[1] form the synchronizer; [2] holds the previous synchronized level.
  logic [2:0]       sync_q, sync_d;
  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    sync_d    = {sync_q[1:0], i_1mhz_clk};
    div_d     = div_q;
    o_us_tick = sync_q[1] & ~sync_q[2];
    o_ms_tick = o_us_tick && (div_q == DIV_LAST);
    if (i_clr) begin
      div_d = '0;
    end else if (o_us_tick) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      div_q  <= '0;
    end else begin
      sync_q <= sync_d;
      div_q  <= div_d;
    end
  end

endmodule

// File: rtl/motor_pwm_sequencer.sv
// Washer motor programme sequencer: ramps PWM duty up, runs, ramps down and
// reverses direction after a dead time, for one SPIN leg or WASH_CYCLES legs.
module motor_pwm_sequencer
  import motor_pwm_sequencer_pkg::*;
#(
  parameter int unsigned DUTY_W       = 8,
  parameter int unsigned RAMP_STEP_US = 1000,
  parameter int unsigned RUN_MS       = 5000,
  parameter int unsigned DEAD_MS      = 500,
  parameter int unsigned WASH_CYCLES  = 8,
  parameter int unsigned TICKS_PER_MS = US_PER_MS
) (
  input  logic              sysclk,
  input  logic              i_rst_n,
  input  logic              i_1mhz_clk,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [1:0]        i_mode,
  input  logic [DUTY_W-1:0] i_target_duty,
  output logic [DUTY_W-1:0] o_duty,
  output logic              o_dir,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_state
);

  localparam int unsigned STEP_W = $clog2(RAMP_STEP_US + 1);
  localparam int unsigned MS_MAX = (RUN_MS > DEAD_MS) ? RUN_MS : DEAD_MS;
  localparam int unsigned MS_W   = $clog2(MS_MAX + 1);
  localparam int unsigned LEG_W  = $clog2(WASH_CYCLES + 1);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RAMP_STEP_US - 1);
  localparam logic [MS_W-1:0]   RUN_LAST  = MS_W'(RUN_MS - 1);
  localparam logic [MS_W-1:0]   DEAD_LAST = MS_W'(DEAD_MS - 1);
  localparam logic [LEG_W-1:0]  LEG_LAST  = LEG_W'(WASH_CYCLES - 1);

  state_e              state_q, state_d;
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic [DUTY_W-1:0]   target_q, target_d;
  logic [1:0]          mode_q, mode_d;
  logic                dir_q, dir_d;
  logic                abort_q, abort_d;
  logic [LEG_W-1:0]    leg_q, leg_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [MS_W-1:0]     ms_q, ms_d;

  logic us_tick, ms_tick, tick_clr, step_done;

  motor_pwm_sequencer_tick_gen #(
    .TICKS_PER_MS(TICKS_PER_MS)
  ) u_tick_gen (
    .clk       (sysclk),
    .rst_n     (i_rst_n),
    .i_1mhz_clk(i_1mhz_clk),
    .i_clr     (tick_clr),
    .o_us_tick (us_tick),
    .o_ms_tick (ms_tick)
  );

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    target_d  = target_q;
    mode_d    = mode_q;
    dir_d     = dir_q;
    abort_d   = abort_q;
    leg_d     = leg_q;
    step_d    = step_q;
    ms_d      = ms_q;
    step_done = us_tick && (step_q == STEP_LAST);

    unique case (state_q)
      ST_IDLE: begin
        if (i_start && !i_stop && mode_valid(i_mode) && (i_target_duty != '0)) begin
          target_d = i_target_duty;
          mode_d   = i_mode;
          dir_d    = 1'b0;
          leg_d    = '0;
          abort_d  = 1'b0;
          state_d  = ST_RAMP_UP;
        end
      end
      ST_RAMP_UP: begin
        if (i_stop) begin
          abort_d = 1'b1;
          state_d = ST_RAMP_DOWN;
        end else if (duty_q == target_q) begin
          state_d = ST_RUN;
        end else if (step_done) begin
          duty_d = duty_q + 1'b1;
          step_d = '0;
        end else if (us_tick) begin
          step_d = step_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          abort_d = 1'b1;
          state_d = ST_RAMP_DOWN;
        end else if (ms_tick) begin
          if (ms_q == RUN_LAST) state_d = ST_RAMP_DOWN;
          else                  ms_d    = ms_q + 1'b1;
        end
      end
      ST_RAMP_DOWN: begin
        if (i_stop) abort_d = 1'b1;
        if (duty_q == '0) begin
          // A stop arriving on the decision cycle still counts as an abort.
          if ((mode_q == MODE_SPIN) || (leg_q == LEG_LAST) || abort_q || i_stop)
            state_d = ST_DONE;
          else
            state_d = ST_DEAD;
        end else if (step_done) begin
          duty_d = duty_q - 1'b1;
          step_d = '0;
        end else if (us_tick) begin
          step_d = step_q + 1'b1;
        end
      end
      ST_DEAD: begin
        if (i_stop) begin
          state_d = ST_DONE;
        end else if (ms_tick) begin
          if (ms_q == DEAD_LAST) begin
            dir_d   = ~dir_q;
            leg_d   = leg_q + 1'b1;
            state_d = ST_RAMP_UP;
          end else begin
            ms_d = ms_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Each state starts its timing from scratch; partial steps are dropped.
    tick_clr = (state_d != state_q);
    if (tick_clr) begin
      step_d = '0;
      ms_d   = '0;
    end
  end

  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      duty_q   <= '0;
      target_q <= '0;
      mode_q   <= MODE_WASH;
      dir_q    <= 1'b0;
      abort_q  <= 1'b0;
      leg_q    <= '0;
      step_q   <= '0;
      ms_q     <= '0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      abort_q  <= abort_d;
      leg_q    <= leg_d;
      step_q   <= step_d;
      ms_q     <= ms_d;
    end
  end

  assign o_duty  = duty_q;
  assign o_dir   = dir_q;
  assign o_busy  = (state_q != ST_IDLE);
  assign o_done  = (state_q == ST_DONE);
  assign o_state = state_q;

endmodule

// File: tb/tb_motor_pwm_sequencer.sv
// Self-checking bench for motor_pwm_sequencer: start-acceptance table, model-
// checked programmes (directed and randomized), stop/abort and reset cases.
`timescale 1ns/1ps
module tb_motor_pwm_sequencer;

  localparam int RAMP = 2;
  localparam int RUNM = 1;
  localparam int DEADM = 1;
  localparam int LEGS = 2;
  localparam int UPM  = 20;   // shortened millisecond keeps the run small

  logic       sysclk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_1mhz_clk = 1'b0;
  logic       i_start = 1'b0;
  logic       i_stop = 1'b0;
  logic [1:0] i_mode = 2'd0;
  logic [7:0] i_target_duty = 8'd0;
  logic [7:0] o_duty;
  logic       o_dir, o_busy, o_done;
  logic [2:0] o_state;

  motor_pwm_sequencer #(
    .DUTY_W(8), .RAMP_STEP_US(RAMP), .RUN_MS(RUNM), .DEAD_MS(DEADM),
    .WASH_CYCLES(LEGS), .TICKS_PER_MS(UPM)
  ) dut (
    .sysclk(sysclk), .i_rst_n(i_rst_n), .i_1mhz_clk(i_1mhz_clk),
    .i_start(i_start), .i_stop(i_stop), .i_mode(i_mode),
    .i_target_duty(i_target_duty), .o_duty(o_duty), .o_dir(o_dir),
    .o_busy(o_busy), .o_done(o_done), .o_state(o_state)
  );

  always #25 sysclk = ~sysclk;
  initial begin
    #137;
    forever #500 i_1mhz_clk = ~i_1mhz_clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Observed duty/direction changes, time-stamped in microseconds.
  typedef struct {int duty; int dir; int t;} ev_t;
  ev_t obs_q[$];
  ev_t exp_q[$];   // t holds the expected gap to the previous event, -1 = free

  int us_now = 0;
  int done_cnt = 0;
  int prev_duty = 0;
  int prev_dir = 0;
  int max_duty = 0;
  bit seen_dead = 0;

  always @(posedge i_1mhz_clk) us_now++;

  always @(negedge sysclk) begin
    if (o_done) done_cnt++;
    if (o_state == 3'd4) seen_dead = 1;
    if (int'(o_duty) > max_duty) max_duty = int'(o_duty);
    if (int'(o_duty) != prev_duty || int'(o_dir) != prev_dir) begin
      if (int'(o_dir) != prev_dir)
        check("dir_change_at_zero_duty", int'(prev_duty == 0 && o_duty == 0), 1);
      obs_q.push_back('{int'(o_duty), int'(o_dir), us_now});
    end
    prev_duty = int'(o_duty);
    prev_dir  = int'(o_dir);
  end

  // Programme expressed as the list of duty/direction values it must pass
  // through and the microsecond gaps between them.
  function automatic void build_expected(input int mode, input int tgt);
    int legs;
    exp_q.delete();
    legs = (mode == 1) ? 1 : LEGS;
    for (int leg = 0; leg < legs; leg++) begin
      int dir = leg % 2;
      if (leg > 0) exp_q.push_back('{0, dir, DEADM * UPM});
      for (int k = 1; k <= tgt; k++)
        exp_q.push_back('{k, dir, (leg == 0 && k == 1) ? -1 : RAMP});
      for (int k = tgt - 1; k >= 0; k--)
        exp_q.push_back('{k, dir, (k == tgt - 1) ? RUNM * UPM + RAMP : RAMP});
    end
  endfunction

  task automatic drive(input logic start, input logic stop,
                       input logic [1:0] mode, input logic [7:0] tgt);
    @(negedge sysclk);
    i_start = start; i_stop = stop; i_mode = mode; i_target_duty = tgt;
    @(negedge sysclk);
    i_start = 1'b0; i_stop = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st, input string nm);
    int c = 0;
    while (o_state != st && c < 10000) begin @(negedge sysclk); c++; end
    check({nm, " state_reached"}, int'(o_state), int'(st));
  endtask

  task automatic wait_done(input int d0, input string nm);
    int c = 0;
    while (done_cnt == d0 && c < 10000) begin @(negedge sysclk); c++; end
    repeat (3) @(negedge sysclk);
    check({nm, " done_pulses"}, done_cnt - d0, 1);
    check({nm, " idle_after"}, int'(o_state), 0);
    check({nm, " busy_after"}, int'(o_busy), 0);
  endtask

  task automatic run_prog(input int mode, input int tgt, input bit noise, input string nm);
    int d0, c, nev;
    build_expected(mode, tgt);
    d0 = done_cnt;
    drive(1'b1, 1'b0, mode[1:0], tgt[7:0]);
    @(negedge sysclk);
    obs_q.delete();
    c = 0;
    while (done_cnt == d0 && c < 10000) begin
      @(negedge sysclk);
      c++;
      i_start = 1'b0;
      if (noise && o_state != 3'd0 && o_state != 3'd5) begin
        if ($urandom_range(0, 31) == 0) begin
          i_start = 1'b1;
          i_mode  = 2'($urandom_range(0, 3));
        end
        if ($urandom_range(0, 15) == 0) i_target_duty = 8'($urandom_range(0, 255));
      end
    end
    i_start = 1'b0;
    wait_done(d0, nm);
    check({nm, " event_count"}, obs_q.size(), exp_q.size());
    nev = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < nev; i++) begin
      check($sformatf("%s ev%0d duty", nm, i), obs_q[i].duty, exp_q[i].duty);
      check($sformatf("%s ev%0d dir", nm, i), obs_q[i].dir, exp_q[i].dir);
      if (i > 0 && exp_q[i].t >= 0)
        check($sformatf("%s ev%0d gap_us", nm, i), obs_q[i].t - obs_q[i-1].t, exp_q[i].t);
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] tgt;
    int         exp_busy;
    int         exp_state;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int d0;

    vecs[0] = '{2'd2, 8'd5, 0, 0};
    vecs[1] = '{2'd3, 8'd5, 0, 0};
    vecs[2] = '{2'd0, 8'd0, 0, 0};
    vecs[3] = '{2'd1, 8'd0, 0, 0};
    vecs[4] = '{2'd0, 8'd3, 1, 1};
    vecs[5] = '{2'd1, 8'd7, 1, 1};

    #310 i_rst_n = 1'b1;
    @(negedge sysclk);
    check("reset duty", int'(o_duty), 0);
    check("reset dir", int'(o_dir), 0);
    check("reset busy", int'(o_busy), 0);
    check("reset done", int'(o_done), 0);
    check("reset state", int'(o_state), 0);

    // Start acceptance: rejected starts stay idle silently; accepted ones are stopped again.
    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      drive(1'b1, 1'b0, vecs[i].mode, vecs[i].tgt);
      check($sformatf("vec%0d busy", i), int'(o_busy), vecs[i].exp_busy);
      check($sformatf("vec%0d state", i), int'(o_state), vecs[i].exp_state);
      if (vecs[i].exp_busy == 1) begin
        drive(1'b0, 1'b1, 2'd0, 8'd0);
        wait_done(d0, $sformatf("vec%0d", i));
      end else begin
        repeat (10) @(negedge sysclk);
        check($sformatf("vec%0d no_done", i), done_cnt - d0, 0);
      end
    end

    run_prog(1, 4, 1'b0, "spin4");
    run_prog(0, 3, 1'b0, "wash3");
    for (int r = 0; r < 4; r++)
      run_prog(int'($urandom_range(0, 1)), int'($urandom_range(1, 6)), 1'b1,
               $sformatf("rand%0d", r));

    // Stop during RUN: ramp down from current duty, no dead time or reversal.
    d0 = done_cnt; seen_dead = 0;
    drive(1'b1, 1'b0, 2'd0, 8'd4);
    wait_state(3'd2, "stop_run");
    repeat (5) @(negedge sysclk);
    drive(1'b0, 1'b1, 2'd0, 8'd4);
    check("stop_run state", int'(o_state), 3);
    check("stop_run duty", int'(o_duty), 4);
    wait_done(d0, "stop_run");
    check("stop_run no_dead", int'(seen_dead), 0);
    check("stop_run dir", int'(o_dir), 0);

    // Stop during DEAD: straight to DONE.
    d0 = done_cnt;
    drive(1'b1, 1'b0, 2'd0, 8'd2);
    wait_state(3'd4, "stop_dead");
    drive(1'b0, 1'b1, 2'd0, 8'd2);
    check("stop_dead state", int'(o_state), 5);
    check("stop_dead done", int'(o_done), 1);
    @(negedge sysclk);
    check("stop_dead idle", int'(o_state), 0);
    check("stop_dead dir", int'(o_dir), 0);
    check("stop_dead pulses", done_cnt - d0, 1);

    // Stop during RAMP_DOWN of a non-final WASH leg: finishes instead of reversing.
    d0 = done_cnt; seen_dead = 0;
    drive(1'b1, 1'b0, 2'd0, 8'd3);
    wait_state(3'd3, "stop_down");
    drive(1'b0, 1'b1, 2'd0, 8'd3);
    wait_done(d0, "stop_down");
    check("stop_down no_dead", int'(seen_dead), 0);
    check("stop_down dir", int'(o_dir), 0);

    // Start and stop together during RAMP_UP: only the stop acts.
    d0 = done_cnt; max_duty = 0;
    drive(1'b1, 1'b0, 2'd1, 8'd5);
    begin
      int c = 0;
      while (o_duty != 8'd2 && c < 10000) begin @(negedge sysclk); c++; end
      check("startstop duty_reached", int'(o_duty), 2);
    end
    drive(1'b1, 1'b1, 2'd0, 8'd9);
    check("startstop state", int'(o_state), 3);
    check("startstop duty", int'(o_duty), 2);
    wait_done(d0, "startstop");
    check("startstop max_duty", max_duty, 2);

    // Asynchronous reset in RUN, then a normal programme.
    d0 = done_cnt;
    drive(1'b1, 1'b0, 2'd1, 8'd4);
    wait_state(3'd2, "rst_run");
    #10 i_rst_n = 1'b0;
    #1;
    check("rst_run duty", int'(o_duty), 0);
    check("rst_run state", int'(o_state), 0);
    check("rst_run done", int'(o_done), 0);
    check("rst_run busy", int'(o_busy), 0);
    repeat (3) @(negedge sysclk);
    #5 i_rst_n = 1'b1;
    repeat (3) @(negedge sysclk);
    check("rst_run no_done", done_cnt - d0, 0);
    run_prog(1, 4, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
